dot_arb_2: RTL and testbench

Two-port packet arbiter that shares one dot_4_4 engine between two AXI4-Stream requesters. It grants the engine to one requester for a whole job: the full input packet through TLAST, then the full result packet through TLAST. Results return to the requester that issued the job. It sits between the DMA-side streams and the single dot engine instance.

---
 rtl/dot_arb_2.sv | 169 ++++++++++++++++
 tb/tb_dot_arb_2.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dot_arb_2.sv
// dot_arb_2: shares one dot engine between two AXI4-Stream requesters.
// A job is held by one requester from the first input beat until the
// result packet's TLAST. Results are steered back to that requester.
// All data paths are zero-latency combinational pass-throughs.
// Optional build macro: DOT_ARB_FIXED_PRI_EN (S0 always wins ties).
module dot_arb_2 #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  // requester 0 job stream
  input  logic [DATA_W-1:0] S0_AXIS_TDATA,
  input  logic              S0_AXIS_TLAST,
  input  logic              S0_AXIS_TVALID,
  output logic              S0_AXIS_TREADY,
  // requester 1 job stream
  input  logic [DATA_W-1:0] S1_AXIS_TDATA,
  input  logic              S1_AXIS_TLAST,
  input  logic              S1_AXIS_TVALID,
  output logic              S1_AXIS_TREADY,
  // engine input
  output logic [DATA_W-1:0] ENG_IN_AXIS_TDATA,
  output logic              ENG_IN_AXIS_TLAST,
  output logic              ENG_IN_AXIS_TVALID,
  input  logic              ENG_IN_AXIS_TREADY,
  // engine result
  input  logic [DATA_W-1:0] ENG_OUT_AXIS_TDATA,
  input  logic              ENG_OUT_AXIS_TLAST,
  input  logic              ENG_OUT_AXIS_TVALID,
  output logic              ENG_OUT_AXIS_TREADY,
  // result to requester 0
  output logic [DATA_W-1:0] R0_AXIS_TDATA,
  output logic              R0_AXIS_TLAST,
  output logic              R0_AXIS_TVALID,
  input  logic              R0_AXIS_TREADY,
  // result to requester 1
  output logic [DATA_W-1:0] R1_AXIS_TDATA,
  output logic              R1_AXIS_TLAST,
  output logic              R1_AXIS_TVALID,
  input  logic              R1_AXIS_TREADY,
  // status
  output logic              grant,
  output logic              busy,
  output logic [CNT_W-1:0]  jobs0,
  output logic [CNT_W-1:0]  jobs1
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t             state_q;
  logic               grant_q;
  logic               rr_last_q;
  logic               out_done_q;
  logic [CNT_W-1:0]   jobs0_q;
  logic [CNT_W-1:0]   jobs1_q;

  logic               send_c;
  logic               conn_c;
  logic [DATA_W-1:0]  sel_tdata_c;
  logic               sel_tlast_c;
  logic               sel_tvalid_c;
  logic               sel_rready_c;
  logic               in_last_hs_c;
  logic               out_last_hs_c;
  logic               done_c;
  logic               pick_c;

  // Phase decode: input path open only in SEND, result path in SEND and DRAIN
  assign send_c = (state_q == ST_SEND);
  assign conn_c = (state_q != ST_IDLE);

  // Granted requester's job stream and result-side ready
  assign sel_tdata_c  = grant_q ? S1_AXIS_TDATA  : S0_AXIS_TDATA;
  assign sel_tlast_c  = grant_q ? S1_AXIS_TLAST  : S0_AXIS_TLAST;
  assign sel_tvalid_c = grant_q ? S1_AXIS_TVALID : S0_AXIS_TVALID;
  assign sel_rready_c = grant_q ? R1_AXIS_TREADY : R0_AXIS_TREADY;

  // Requester to engine pass-through
  assign ENG_IN_AXIS_TDATA  = sel_tdata_c;
  assign ENG_IN_AXIS_TLAST  = sel_tlast_c;
  assign ENG_IN_AXIS_TVALID = send_c & sel_tvalid_c;
  assign S0_AXIS_TREADY     = send_c & ~grant_q & ENG_IN_AXIS_TREADY;
  assign S1_AXIS_TREADY     = send_c &  grant_q & ENG_IN_AXIS_TREADY;

  // Engine to owner pass-through; data fans out, only TVALID is steered
  assign ENG_OUT_AXIS_TREADY = conn_c & sel_rready_c;
  assign R0_AXIS_TDATA       = ENG_OUT_AXIS_TDATA;
  assign R0_AXIS_TLAST       = ENG_OUT_AXIS_TLAST;
  assign R0_AXIS_TVALID      = conn_c & ~grant_q & ENG_OUT_AXIS_TVALID;
  assign R1_AXIS_TDATA       = ENG_OUT_AXIS_TDATA;
  assign R1_AXIS_TLAST       = ENG_OUT_AXIS_TLAST;
  assign R1_AXIS_TVALID      = conn_c &  grant_q & ENG_OUT_AXIS_TVALID;

  // Packet-boundary handshakes and job completion
  assign in_last_hs_c  = ENG_IN_AXIS_TVALID & ENG_IN_AXIS_TREADY & sel_tlast_c;
  assign out_last_hs_c = ENG_OUT_AXIS_TVALID & ENG_OUT_AXIS_TREADY & ENG_OUT_AXIS_TLAST;
  assign done_c = (send_c & in_last_hs_c & (out_done_q | out_last_hs_c)) |
                  ((state_q == ST_DRAIN) & out_last_hs_c);

  // Owner selection for the next job
  always_comb begin
    pick_c = 1'b0;
`ifdef DOT_ARB_FIXED_PRI_EN
    pick_c = ~S0_AXIS_TVALID;
`else
    if (S0_AXIS_TVALID && S1_AXIS_TVALID) begin
      pick_c = ~rr_last_q;
    end else begin
      pick_c = S1_AXIS_TVALID;
    end
`endif
  end

  // Job FSM, grant, round-robin history and completion counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      grant_q    <= 1'b0;
      rr_last_q  <= 1'b1;
      out_done_q <= 1'b0;
      jobs0_q    <= '0;
      jobs1_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (S0_AXIS_TVALID || S1_AXIS_TVALID) begin
            grant_q <= pick_c;
            state_q <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (out_last_hs_c) begin
            out_done_q <= 1'b1;
          end
          if (in_last_hs_c) begin
            state_q <= (out_done_q || out_last_hs_c) ? ST_IDLE : ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (out_last_hs_c) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
      // Completion bookkeeping; placed last so the out_done clear wins
      if (done_c) begin
        rr_last_q  <= grant_q;
        out_done_q <= 1'b0;
        if (grant_q) begin
          jobs1_q <= jobs1_q + CNT_W'(1);
        end else begin
          jobs0_q <= jobs0_q + CNT_W'(1);
        end
      end
    end
  end

  assign grant = grant_q;
  assign busy  = conn_c;
  assign jobs0 = jobs0_q;
  assign jobs1 = jobs1_q;

endmodule

// File: tb/tb_dot_arb_2.sv
// tb_dot_arb_2: randomized bench for dot_arb_2 with a job-level reference
// model (owner choice, job phases, result steering, completion counts).
// Counters are built 2 bits wide so that wrap-around is exercised.
module tb_dot_arb_2;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 2;
  localparam int unsigned NCYC   = 6000;

  logic clk = 1'b0;
  logic rst;

  logic [DATA_W-1:0] s_d [2];
  logic [1:0]        s_l;
  logic [1:0]        s_vld;
  logic              s0_rdy, s1_rdy;
  logic [DATA_W-1:0] eng_in_d;
  logic              eng_in_l, eng_in_v, eng_in_rdy;
  logic [DATA_W-1:0] eng_out_d;
  logic              eng_out_l, eng_out_v, eng_out_rdy;
  logic [DATA_W-1:0] r0_d, r1_d;
  logic              r0_l, r1_l, r0_v, r1_v;
  logic [1:0]        r_rdy;
  logic              grant, busy;
  logic [CNT_W-1:0]  jobs0, jobs1;

  dot_arb_2 #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .S0_AXIS_TDATA       (s_d[0]),
    .S0_AXIS_TLAST       (s_l[0]),
    .S0_AXIS_TVALID      (s_vld[0]),
    .S0_AXIS_TREADY      (s0_rdy),
    .S1_AXIS_TDATA       (s_d[1]),
    .S1_AXIS_TLAST       (s_l[1]),
    .S1_AXIS_TVALID      (s_vld[1]),
    .S1_AXIS_TREADY      (s1_rdy),
    .ENG_IN_AXIS_TDATA   (eng_in_d),
    .ENG_IN_AXIS_TLAST   (eng_in_l),
    .ENG_IN_AXIS_TVALID  (eng_in_v),
    .ENG_IN_AXIS_TREADY  (eng_in_rdy),
    .ENG_OUT_AXIS_TDATA  (eng_out_d),
    .ENG_OUT_AXIS_TLAST  (eng_out_l),
    .ENG_OUT_AXIS_TVALID (eng_out_v),
    .ENG_OUT_AXIS_TREADY (eng_out_rdy),
    .R0_AXIS_TDATA       (r0_d),
    .R0_AXIS_TLAST       (r0_l),
    .R0_AXIS_TVALID      (r0_v),
    .R0_AXIS_TREADY      (r_rdy[0]),
    .R1_AXIS_TDATA       (r1_d),
    .R1_AXIS_TLAST       (r1_l),
    .R1_AXIS_TVALID      (r1_v),
    .R1_AXIS_TREADY      (r_rdy[1]),
    .grant               (grant),
    .busy                (busy),
    .jobs0               (jobs0),
    .jobs1               (jobs1)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Requester drivers: pending beats {last, data} per requester
  logic [DATA_W:0] pend [2][$];
  bit              hold [2];
  // Engine stand-in: one result packet per job, may start before input ends
  logic [DATA_W:0] res [$];
  bit              e_act, e_in_done, e_out_done, e_hold;
  // Reference model of the job sequence
  bit              m_busy, m_owner, m_rr_last, m_in_done, m_out_done;
  int              m_jobs [2];
  int              m_words [2];
  int              got_words [2];
  int              m_total = 0;
  bit              force_both;

  task automatic clear_all();
    for (int i = 0; i < 2; i++) begin
      pend[i].delete();
      hold[i]      = 1'b0;
      m_jobs[i]    = 0;
      m_words[i]   = 0;
      got_words[i] = 0;
    end
    res.delete();
    {e_act, e_in_done, e_out_done, e_hold} = '0;
    {m_busy, m_owner, m_in_done, m_out_done} = '0;
    m_rr_last  = 1'b1;
    s_vld      = '0;
    s_l        = '0;
    s_d[0]     = '0;
    s_d[1]     = '0;
    eng_out_v  = 1'b0;
    eng_out_l  = 1'b0;
    eng_out_d  = '0;
    eng_in_rdy = 1'b0;
    r_rdy      = '0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'(0));
    check({tag, "_grant"}, 32'(grant), 32'(0));
    check({tag, "_vr"}, 32'({eng_in_v, s0_rdy, s1_rdy, eng_out_rdy, r0_v, r1_v}), 32'(0));
    check({tag, "_jobs"}, 32'({jobs1, jobs0}), 32'(0));
  endtask

  // Called at the falling edge: compare against the model, then advance
  task automatic monitor();
    bit              o, pick, exp_in_v, in_hs, out_hs;
    logic [1:0]      exp_rdy, exp_rv;
    logic [DATA_W-1:0] rd;
    logic            rl;
    check("jobs0", 32'(jobs0), 32'(m_jobs[0] % (1 << CNT_W)));
    check("jobs1", 32'(jobs1), 32'(m_jobs[1] % (1 << CNT_W)));
    if (!m_busy) begin
      check("busy_idle", 32'(busy), 32'(0));
      check("vr_idle", 32'({eng_in_v, s0_rdy, s1_rdy, eng_out_rdy, r0_v, r1_v}), 32'(0));
      if (s_vld != 2'b00) begin
`ifdef DOT_ARB_FIXED_PRI_EN
        pick = !s_vld[0];
`else
        pick = (s_vld == 2'b11) ? !m_rr_last : s_vld[1];
`endif
        m_owner    = pick;
        m_busy     = 1'b1;
        m_in_done  = 1'b0;
        m_out_done = 1'b0;
      end
    end else begin
      o = m_owner;
      check("busy", 32'(busy), 32'(1));
      check("grant", 32'(grant), 32'(o));
      exp_in_v = !m_in_done && s_vld[o];
      check("eng_in_v", 32'(eng_in_v), 32'(exp_in_v));
      if (exp_in_v) begin
        check("eng_in_d", eng_in_d, s_d[o]);
        check("eng_in_l", 32'(eng_in_l), 32'(s_l[o]));
      end
      exp_rdy = '0;
      if (!m_in_done && eng_in_rdy) exp_rdy[o] = 1'b1;
      check("s_rdy", 32'({s1_rdy, s0_rdy}), 32'(exp_rdy));
      check("eng_out_rdy", 32'(eng_out_rdy), 32'(r_rdy[o]));
      exp_rv = '0;
      if (eng_out_v) exp_rv[o] = 1'b1;
      check("r_v", 32'({r1_v, r0_v}), 32'(exp_rv));
      in_hs  = exp_in_v && eng_in_rdy;
      out_hs = eng_out_v && r_rdy[o];
      if (out_hs) begin
        rd = o ? r1_d : r0_d;
        rl = o ? r1_l : r0_l;
        check("r_d", rd, eng_out_d);
        check("r_l", 32'(rl), 32'(eng_out_l));
        m_words[o]++;
      end
      if (in_hs && s_l[o]) m_in_done = 1'b1;
      if (out_hs && eng_out_l) m_out_done = 1'b1;
      if (m_in_done && m_out_done) begin
        m_jobs[o]++;
        m_total++;
        m_rr_last = o;
        m_busy    = 1'b0;
      end
    end
    // advance stimulus from what the DUT actually accepted
    if (r0_v && r_rdy[0]) got_words[0]++;
    if (r1_v && r_rdy[1]) got_words[1]++;
    for (int i = 0; i < 2; i++) begin
      if (s_vld[i] && (i == 1 ? s1_rdy : s0_rdy)) begin
        void'(pend[i].pop_front());
        hold[i] = 1'b0;
      end else begin
        hold[i] = s_vld[i];
      end
    end
    if (eng_in_v && eng_in_rdy) begin
      if (!e_act) begin
        int n;
        e_act = 1'b1;
        n = $urandom_range(1, 4);
        for (int k = 0; k < n; k++) res.push_back({1'(k == n - 1), DATA_W'($urandom)});
      end
      if (eng_in_l) e_in_done = 1'b1;
    end
    if (eng_out_v && eng_out_rdy) begin
      void'(res.pop_front());
      e_hold = 1'b0;
      if (eng_out_l) e_out_done = 1'b1;
    end else begin
      e_hold = eng_out_v;
    end
    if (e_in_done && e_out_done) {e_act, e_in_done, e_out_done} = '0;
  endtask

  // Called just after the rising edge: new random input values
  task automatic drive();
    for (int i = 0; i < 2; i++) begin
      if (!hold[i]) begin
        if (pend[i].size() == 0 && (force_both || $urandom_range(0, 2) == 0)) begin
          int len;
          len = $urandom_range(1, 8);
          for (int k = 0; k < len; k++) pend[i].push_back({1'(k == len - 1), DATA_W'($urandom)});
        end
        s_vld[i] = (pend[i].size() != 0) && (force_both || $urandom_range(0, 3) != 0);
      end
      if (pend[i].size() != 0) {s_l[i], s_d[i]} = pend[i][0];
    end
    if (!e_hold) eng_out_v = (res.size() != 0) && ($urandom_range(0, 2) != 0);
    if (res.size() != 0) {eng_out_l, eng_out_d} = res[0];
    eng_in_rdy = 1'($urandom_range(0, 1));
    r_rdy[0]   = ($urandom_range(0, 3) != 0);
    r_rdy[1]   = ($urandom_range(0, 3) != 0);
  endtask

  initial begin
    bit did_rst;
    did_rst = 1'b0;
    force_both = 1'b0;
    rst = 1'b1;
    clear_all();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_state("por");
    @(posedge clk);
    #1;
    rst = 1'b0;
    force_both = 1'b1;
    drive();
    force_both = 1'b0;
    for (int c = 0; c < int'(NCYC); c++) begin
      @(negedge clk);
      monitor();
      if (!did_rst && c >= 3000 && ((m_busy && m_owner && !m_in_done) || c >= 5000)) begin
        did_rst = 1'b1;
        rst = 1'b1;
        #1;
        check_reset_state("mid");
        clear_all();
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive();
      end else begin
        @(posedge clk);
        #1;
        drive();
      end
    end
    @(negedge clk);
    check("words0", 32'(got_words[0]), 32'(m_words[0]));
    check("words1", 32'(got_words[1]), 32'(m_words[1]));
    check("jobs_min", 32'(m_total >= 20), 32'(1));
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
